// File: rtl/sd_dma_pkg.sv
// Shared constants, FSM state type and burst wrap-mask helper for the SD DMA
// Wishbone responder.
package sd_dma_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_BURST
    } dma_state_t;

    // Bits of the offset that advance during a burst; the rest stay fixed.
    function automatic logic [31:0] wrap_mask(input logic [1:0] bte);
        case (bte)
            BTE_WRAP4:  return 32'h3;
            BTE_WRAP8:  return 32'h7;
            BTE_WRAP16: return 32'hF;
            default:    return '1;
        endcase
    endfunction

endpackage

// File: rtl/sd_dma_sector_ram.sv
// Sector buffer: one byte-enabled write port, two registered read ports.
// Each byte lane is its own memory so byte-write block RAM maps cleanly.
module sd_dma_sector_ram
    import sd_dma_pkg::*;
#(
    parameter int DEPTH = 128
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [SEL_W-1:0]         sel,
    input  logic [$clog2(DEPTH)-1:0] wr_adr,
    input  logic [31:0]              wr_dat,
    input  logic [$clog2(DEPTH)-1:0] rd_adr_a,
    output logic [31:0]              rd_dat_a,
    input  logic [$clog2(DEPTH)-1:0] rd_adr_b,
    output logic [31:0]              rd_dat_b
);

    for (genvar l = 0; l < SEL_W; l++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] q_a, q_b;

        always_ff @(posedge clk)
            if (we && sel[l]) mem[wr_adr] <= wr_dat[8*l +: 8];

        // Read-before-write: a same-edge write is not visible on either port.
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                q_a <= '0;
                q_b <= '0;
            end else begin
                q_a <= mem[rd_adr_a];
                q_b <= mem[rd_adr_b];
            end

        assign rd_dat_a[8*l +: 8] = q_a;
        assign rd_dat_b[8*l +: 8] = q_b;
    end

endmodule

// File: rtl/sd_dma_wb_responder.sv
// Wishbone B4 responder for the SD DMA master, backed by a sector buffer.
// Define WB_DMA_BURST_EN to enable incrementing/wrapping bursts.
module sd_dma_wb_responder
    import sd_dma_pkg::*;
#(
    parameter logic [29:0] BASE_ADR    = 30'h0,
    parameter int          DEPTH       = 128,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wb_dma_cyc,
    input  logic                     wb_dma_stb,
    input  logic                     wb_dma_we,
    input  logic [29:0]              wb_dma_adr,
    input  logic [3:0]               wb_dma_sel,
    input  logic [2:0]               wb_dma_cti,
    input  logic [1:0]               wb_dma_bte,
    input  logic [31:0]              wb_dma_dat_w,
    output logic [31:0]              wb_dma_dat_r,
    output logic                     wb_dma_ack,
    output logic                     wb_dma_err,
    input  logic [$clog2(DEPTH)-1:0] host_rd_adr,
    output logic [31:0]              host_rd_dat,
    output logic                     sector_done,
    output logic [$clog2(DEPTH):0]   wr_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_OFF = AW'(DEPTH - 1);
    localparam logic [AW:0]   WR_SAT   = (AW+1)'(DEPTH);

    dma_state_t    state, state_nxt;
    logic [2:0]    wait_cnt;
    logic [AW-1:0] off, off_nxt;
    logic [29:0]   adr_diff;
    logic          in_range, beat, ram_we;
    logic [31:0]   ram_q;

    assign adr_diff = wb_dma_adr - BASE_ADR;
    assign in_range = adr_diff < 30'(DEPTH);

`ifdef WB_DMA_BURST_EN
    logic [AW-1:0] wmask, next_off;
    assign wmask    = AW'(wrap_mask(wb_dma_bte));
    assign next_off = (off & ~wmask) | ((off + AW'(1)) & wmask);
`else
    logic unused_burst;
    assign unused_burst = ^{wb_dma_cti, wb_dma_bte};
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = state;
        if (!wb_dma_cyc) state_nxt = ST_IDLE;
        else case (state)
            ST_IDLE:  if (wb_dma_stb) state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACK;
            ST_WAIT:  if (int'(wait_cnt) >= WAIT_CYCLES - 1) state_nxt = ST_ACK;
`ifdef WB_DMA_BURST_EN
            ST_ACK:   state_nxt = (wb_dma_stb && wb_dma_cti == CTI_INCR) ? ST_BURST : ST_IDLE;
            ST_BURST: if (wb_dma_stb && wb_dma_cti == CTI_EOB) state_nxt = ST_IDLE;
`else
            ST_ACK:   state_nxt = ST_IDLE;
`endif
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // The read port is fed the offset of the upcoming beat so RAM data lines up with ack.
    always_comb begin
        beat    = 1'b0;
        off_nxt = adr_diff[AW-1:0];
        if (state == ST_ACK || state == ST_BURST) begin
            beat    = wb_dma_cyc & wb_dma_stb;
            off_nxt = off;
`ifdef WB_DMA_BURST_EN
            if (beat) off_nxt = next_off;
`endif
        end
    end

    assign wb_dma_ack   = beat & in_range;
    assign wb_dma_err   = beat & ~in_range;
    assign wb_dma_dat_r = wb_dma_ack ? ram_q : '0;
    assign ram_we       = wb_dma_ack & wb_dma_we;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            off      <= '0;
            wait_cnt <= '0;
        end else begin
            off      <= off_nxt;
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 3'd1 : 3'd0;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sector_done <= 1'b0;
            wr_count    <= '0;
        end else begin
            sector_done <= 1'b0;
            if (ram_we) begin
                if (off == LAST_OFF) begin
                    sector_done <= 1'b1;
                    wr_count    <= '0;
                end else if (wr_count != WR_SAT) begin
                    wr_count <= wr_count + 1'b1;
                end
            end
        end

    sd_dma_sector_ram #(.DEPTH(DEPTH)) u_ram (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (ram_we),
        .sel      (wb_dma_sel),
        .wr_adr   (off),
        .wr_dat   (wb_dma_dat_w),
        .rd_adr_a (off_nxt),
        .rd_dat_a (ram_q),
        .rd_adr_b (host_rd_adr),
        .rd_dat_b (host_rd_dat)
    );

endmodule
